// File: rtl/axi_master_pkg.sv
// axi_master_pkg: shared state encoding, AXI constants and beat-size helper for the burst master
package axi_master_pkg;
  typedef enum logic [3:0] {S_IDLE, S_CHK, S_AW, S_W, S_B, S_AR, S_R, S_ERR, S_DONE} state_t;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [3:0] AXI_CACHE       = 4'b0011;
  function automatic logic [2:0] axsize(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one write/read command into a single AXI4 INCR burst on the DDR slave port
module axi_burst_master import axi_master_pkg::*; #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  localparam logic [2:0] AXSIZE = axsize(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_KEEP = {ADDR_WIDTH{1'b1}} << AXSIZE;
  state_t r_state, w_next;
  logic                  r_write, r_ovf;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_resp;
  logic [31:0]           w_end;
  logic                  w_cross, w_cmd_hs, w_w_hs, w_r_hs, w_unused_ids;
  assign w_unused_ids = ^{m_axi_bid, m_axi_rid};
  assign w_end    = {20'd0, r_addr[11:0]} + ((32'(r_len) + 32'd1) << AXSIZE);
  assign w_cross  = w_end > 32'd4096;
  assign w_cmd_hs = cmd_valid & cmd_ready;
  assign w_w_hs   = m_axi_wvalid & m_axi_wready;
  assign w_r_hs   = m_axi_rvalid & m_axi_rready;
  assign cmd_ready     = r_state == S_IDLE;
  assign done_valid    = r_state == S_DONE;
  assign done_resp     = r_resp;
  assign m_axi_awvalid = r_state == S_AW;
  assign m_axi_arvalid = r_state == S_AR;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_araddr  = r_addr;
  assign m_axi_awlen   = r_len;
  assign m_axi_arlen   = r_len;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE;
  assign m_axi_arcache = AXI_CACHE;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_wvalid  = (r_state == S_W) & wr_valid;
  assign wr_ready      = (r_state == S_W) & m_axi_wready;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign m_axi_wlast   = (r_state == S_W) & (r_cnt == r_len);
  assign m_axi_bready  = r_state == S_B;
  assign rd_valid      = (r_state == S_R) & m_axi_rvalid;
  assign m_axi_rready  = (r_state == S_R) & rd_ready;
  assign rd_data       = m_axi_rdata;
  assign rd_last       = (r_state == S_R) & m_axi_rlast;
  always_ff @(posedge axi_clk)
    r_state <= axi_reset ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = cmd_valid ? S_CHK : S_IDLE;
      S_CHK:  w_next = w_cross ? S_ERR : (r_write ? S_AW : S_AR);
      S_AW:   w_next = m_axi_awready ? S_W : S_AW;
      S_W:    w_next = (w_w_hs && r_cnt == r_len) ? S_B : S_W;
      S_B:    w_next = m_axi_bvalid ? S_DONE : S_B;
      S_AR:   w_next = m_axi_arready ? S_R : S_AR;
      S_R:    w_next = (w_r_hs && m_axi_rlast) ? S_DONE : S_R;
      S_ERR:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // A read burst whose rlast disagrees with the beat count is reported as SLVERR
  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_resp  <= AXI_RESP_OKAY;
      r_ovf   <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr & ADDR_KEEP;
        r_len   <= cmd_len;
        r_cnt   <= '0;
        r_resp  <= AXI_RESP_OKAY;
        r_ovf   <= 1'b0;
      end
      if (r_state == S_ERR) r_resp <= AXI_RESP_SLVERR;
      if (w_w_hs) r_cnt <= r_cnt + 8'd1;
      if (m_axi_bready && m_axi_bvalid) r_resp <= m_axi_bresp;
      if (w_r_hs) begin
        r_cnt <= r_cnt + 8'd1;
        if (!m_axi_rlast && r_cnt == r_len) r_ovf <= 1'b1;
        r_resp <= (m_axi_rlast && (r_ovf || r_cnt != r_len)) ? AXI_RESP_SLVERR :
                  (m_axi_rresp > r_resp ? m_axi_rresp : r_resp);
      end
    end
  end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed and randomized bursts against a transaction-level model of the engine
module tb_axi_burst_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, cmd_valid, cmd_ready, cmd_write;
  logic [27:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [127:0] wr_data, rd_data, m_axi_wdata, m_axi_rdata;
  logic [15:0] wr_strb, m_axi_wstrb;
  logic wr_valid, wr_ready, rd_last, rd_valid, rd_ready, done_valid;
  logic [1:0] done_resp;
  logic [3:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [27:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0] m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic m_axi_awlock, m_axi_arlock, m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [3:0] m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_burst_master dut (
    .axi_clk(clk), .axi_reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done_valid(done_valid), .done_resp(done_resp),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int checks = 0, errors = 0;
  logic [127:0] d[256];
  logic [15:0] s[256];
  logic [1:0] rr[256];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_strb = '0; wr_valid = 0; rd_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    m_axi_rvalid = 0;
  endtask

  task automatic send_cmd(input bit wr, input logic [27:0] a, input logic [7:0] l);
    bit hs = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = cmd_ready;
      next_cyc();
    end
    cmd_valid = 0;
    if (!hs) check("cmd_timeout", 0, 1);
  endtask

  task automatic done_check(input logic [1:0] exp);
    @(negedge clk);
    check("done_pulse", done_valid, 1);
    check("done_resp", done_resp, exp);
    next_cyc();
    @(negedge clk);
    check("done_one_cycle", done_valid, 0);
    check("ready_after_done", cmd_ready, 1);
    next_cyc();
  endtask

  task automatic err_path();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("err_no_addr", m_axi_awvalid | m_axi_arvalid, 0);
      check("err_done_timing", done_valid, c == 3);
      if (c == 3) check("err_resp", done_resp, 2'b10);
      next_cyc();
    end
    @(negedge clk);
    check("err_ready", cmd_ready, 1);
    next_cyc();
  endtask

  task automatic addr_phase(input bit wr, input logic [27:0] a, input logic [7:0] l, input bit stall);
    bit hs = 0;
    logic [27:0] ea = a & 28'hFFFFFF0;
    @(negedge clk);
    check("addr_early", m_axi_awvalid | m_axi_arvalid, 0);
    next_cyc();
    for (int n = 0; n < 200 && !hs; n++) begin
      m_axi_awready = stall ? 1'($urandom % 2) : 1'b1;
      m_axi_arready = m_axi_awready;
      @(negedge clk);
      if (n == 0) check("addr_latency", wr ? m_axi_awvalid : m_axi_arvalid, 1);
      if (wr ? (m_axi_awvalid && m_axi_awready) : (m_axi_arvalid && m_axi_arready)) begin
        hs = 1;
        check("addr", wr ? m_axi_awaddr : m_axi_araddr, ea);
        check("len", wr ? m_axi_awlen : m_axi_arlen, l);
        check("size", wr ? m_axi_awsize : m_axi_arsize, 3'd4);
        check("burst", wr ? m_axi_awburst : m_axi_arburst, 2'b01);
        check("cache", wr ? m_axi_awcache : m_axi_arcache, 4'b0011);
      end
      next_cyc();
    end
    m_axi_awready = 0; m_axi_arready = 0;
    if (!hs) check("addr_timeout", 0, 1);
  endtask

  task automatic run_cmd(input bit wr, input logic [27:0] a, input logic [7:0] l, input bit stall,
                         input logic [1:0] bresp);
    int beat = 0;
    bit hs = 0;
    logic [1:0] worst = 2'b00;
    bit err = (int'(a[11:4]) * 16 + (int'(l) + 1) * 16) > 4096;
    for (int i = 0; i <= int'(l); i++) begin
      d[i] = {$urandom, $urandom, $urandom, $urandom};
      s[i] = 16'($urandom);
      if (rr[i] > worst) worst = rr[i];
    end
    send_cmd(wr, a, l);
    if (err) begin
      err_path();
      return;
    end
    addr_phase(wr, a, l, stall);
    if (wr) begin
      for (int n = 0; n < 20000 && beat <= int'(l); n++) begin
        wr_valid = stall ? ($urandom % 3 != 0) : 1'b1;
        m_axi_wready = stall ? ($urandom % 3 != 0) : 1'b1;
        wr_data = d[beat]; wr_strb = s[beat];
        @(negedge clk);
        if (m_axi_wvalid && m_axi_wready) begin
          check("wdata", m_axi_wdata, d[beat]);
          check("wstrb", m_axi_wstrb, s[beat]);
          check("wlast", m_axi_wlast, beat == int'(l));
          beat++;
        end
        next_cyc();
      end
      wr_valid = 0; m_axi_wready = 0;
      check("w_beats", beat, int'(l) + 1);
      m_axi_bresp = bresp;
      for (int n = 0; n < 200 && !hs; n++) begin
        m_axi_bvalid = stall ? 1'($urandom % 2) : 1'b1;
        @(negedge clk);
        check("b_no_wready", wr_ready, 0);
        hs = m_axi_bvalid && m_axi_bready;
        next_cyc();
      end
      m_axi_bvalid = 0;
      if (!hs) check("b_timeout", 0, 1);
      done_check(bresp);
    end else begin
      for (int n = 0; n < 20000 && !hs; n++) begin
        m_axi_rvalid = stall ? ($urandom % 3 != 0) : 1'b1;
        rd_ready = stall ? ($urandom % 3 != 0) : 1'b1;
        m_axi_rdata = d[beat]; m_axi_rresp = rr[beat]; m_axi_rlast = beat == int'(l);
        @(negedge clk);
        if (rd_valid && m_axi_rready) begin
          check("rd_data", rd_data, d[beat]);
          check("rd_last", rd_last, beat == int'(l));
          hs = beat == int'(l);
          beat++;
        end
        next_cyc();
      end
      m_axi_rvalid = 0; rd_ready = 0; m_axi_rlast = 0;
      check("r_beats", beat, int'(l) + 1);
      done_check(worst);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    for (int i = 0; i < 256; i++) rr[i] = 2'b00;
    rst = 1;
    wr_valid = 1; m_axi_wready = 1; rd_ready = 1; m_axi_rvalid = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_done", done_valid, 0);
    check("rst_resp", done_resp, 0);
    idle_in();
    next_cyc();
    run_cmd(1, 28'h0000100, 8'd3, 0, 2'b00);
    run_cmd(0, 28'h0000200, 8'd0, 0, 2'b00);
    run_cmd(1, 28'h0000F80, 8'd8, 0, 2'b00);
    rr[7] = 2'b10;
    run_cmd(0, 28'h0000400, 8'd15, 1, 2'b00);
    rr[7] = 2'b00;
    run_cmd(1, 28'h0000000, 8'd255, 1, 2'b00);
    run_cmd(0, 28'h0000F00, 8'd15, 1, 2'b00);
    run_cmd(1, 28'h0001F05, 8'd1, 1, 2'b11);
    // Reset lands while the second W beat is presented
    send_cmd(1, 28'h0000300, 8'd7);
    @(negedge clk);
    next_cyc();
    m_axi_awready = 1;
    @(negedge clk);
    next_cyc();
    m_axi_awready = 0; wr_valid = 1; m_axi_wready = 1;
    @(negedge clk);
    check("rstw_beat1", m_axi_wvalid, 1);
    next_cyc();
    rst = 1;
    @(negedge clk);
    check("rstw_beat2", m_axi_wvalid, 1);
    next_cyc();
    rst = 0;
    @(negedge clk);
    check("rstw_awvalid", m_axi_awvalid, 0);
    check("rstw_wvalid", m_axi_wvalid, 0);
    check("rstw_wr_ready", wr_ready, 0);
    check("rstw_bready", m_axi_bready, 0);
    check("rstw_cmd_ready", cmd_ready, 1);
    check("rstw_done", done_valid, 0);
    idle_in();
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      @(negedge clk);
      check("rstw_no_done", done_valid, 0);
    end
    next_cyc();
    for (int k = 0; k < 8; k++) begin
      logic [27:0] a = 28'($urandom) | 28'h0000E00;
      logic [7:0] l = 8'($urandom % 32);
      for (int i = 0; i < 256; i++) rr[i] = 2'($urandom);
      run_cmd(1'($urandom % 2), a, l, 1, 2'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
